mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single byte-addressed memory (one read port with one-cycle registered read latency, one sized write port) between the instruction-fetch and load/store units. Each cycle it arbitrates the read port round-robin, passes stores straight to the write port, defers fetches that overlap a same-cycle store, and returns responses one cycle after acceptance. It also sign- or zero-extends load data. It sits between the pipeline front/back ends and the memory instance.

## Interface
- SIZE, 1024, memory size in bytes; must match the memory instance; address overlap is computed modulo SIZE
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch accepted this cycle (valid & ready)
- i_req_addr  in  32  fetch byte address
- i_rsp_valid  out  1  fetch response valid; no backpressure
- i_rsp_data  out  32  fetched word, little-endian
- d_req_valid  in  1  load/store request
- d_req_ready  out  1  data request accepted this cycle
- d_req_we  in  1  1 = store, 0 = load
- d_req_size  in  2  0 = none, 1 = byte, 2 = half, 3 = word (memory wr encoding)
- d_req_unsigned  in  1  load zero-extend (1) or sign-extend (0)
- d_req_addr  in  32  data byte address
- d_req_wdata  in  32  store data, low bytes used
- d_rsp_valid  out  1  data response valid, for loads and stores; no backpressure
- d_rsp_data  out  32  extended load data; 0 for stores
- mem_rd_addr  out  32  to memory read address
- mem_rd_data  in  32  from memory; valid the cycle after the address is presented
- mem_wr  out  2  to memory write size; 0 when no store
- mem_wr_addr  out  32  to memory write address
- mem_wr_data  out  32  to memory write data

## Operation
- Stores are always accepted: when d_req_valid & d_req_we, d_req_ready=1 and mem_wr/addr/data = d_req_size/addr/wdata in the same cycle (combinational).
- Read candidates are a fetch (i_req_valid) and a load (d_req_valid & !d_req_we).
  - One candidate: it is granted.
  - Both: grant the one not granted last. The last_rd register updates only on a read grant; its reset value is "data", so fetch wins the first tie.
- Overlap deferral: with a store of n bytes at w and a fetch at r, overlap = ((w-r) mod SIZE) < 4 or ((r-w) mod SIZE) < n. On overlap, i_req_ready=0 and the fetch is not a read candidate this cycle. last_rd is unchanged.
- mem_rd_addr = the granted address, else 0. mem_wr = 0 when no store is accepted.
- Response registers are set at the acceptance edge:
  - i_pend is set for an accepted fetch.
  - d_pend is set for an accepted data request.
  - d_kind captures load/store, size and unsigned.
- i_rsp_valid = i_pend; i_rsp_data = mem_rd_data.
- d_rsp_valid = d_pend.
- d_rsp_data, from the byte/half at the low-order bytes of mem_rd_data (the load address is the low byte):
  - byte: bits 7:0, extended per unsigned
  - half: bits 15:0, extended per unsigned
  - word: mem_rd_data
  - size 0 or store: 0
- A size-0 store is accepted with mem_wr=0 and still produces a response.
- Misaligned addresses are legal; the memory wraps modulo SIZE.

## Timing
- Request accepted in cycle N → memory samples the address at the end of N → response valid in cycle N+1 with data. Throughput is one read plus one store per cycle.
- A store accepted in N is visible to any read accepted in N+1 or later.
- Requests may be back-to-back; the response for N and the acceptance for N+1 share cycle N+1.
- Reset (async, any time):
  - i_pend, d_pend → 0, so i_rsp_valid = d_rsp_valid = 0 immediately.
  - last_rd → data; in-flight responses are dropped.
  - Combinational outputs follow inputs, except no response is issued.
  - Memory contents are not reset.
- Requesters must hold valid and payload stable until ready. The arbiter holds no request state, so de-asserting an unaccepted request is harmless.

## Test plan
- Fetch only, addr 0x0, memory bytes 0..3 = 0x13,0x05,0x10,0x00 → i_req_ready same cycle; next cycle i_rsp_valid=1, i_rsp_data=0x00100513.
- Store word 0xDEADBEEF at 0x10, then load at 0x11 with size=1, unsigned=0 → d_rsp_data=0xFFFFFFBE; same load with unsigned=1 → 0x000000BE; half at 0x10 signed → 0xFFFFBEEF.
- Fetch 0x20 and load 0x40 held valid for 4 cycles after reset → grants alternate I,D,I,D; each response valid exactly one cycle after its grant.
- Same-cycle store byte at 0x23 with fetch at 0x20 → store accepted, i_req_ready=0; fetch accepted the next cycle and returns the new byte in bits 31:24. Store at 0x24 with fetch at 0x20 → both accepted.
- Wrap-around with SIZE=1024: store half at 0x3FF with fetch at 0x0 → overlap, fetch deferred.
- Assert rst_n low mid-cycle after a load acceptance → d_rsp_valid=0 immediately and no response after release; the first tie after release grants fetch.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one registered-read / sized-write memory between instruction fetch and load/store.
// Round-robin read arbitration, same-cycle store forwarding to the write port, load extension.
module mem_port_arbiter #(
    parameter int unsigned SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [1:0]  d_req_size,
    input  logic        d_req_unsigned,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic [31:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic [1:0]  mem_wr,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data
);

    logic        storeAcc;
    logic        fetchCand;
    logic        loadCand;
    logic        overlap;
    logic        grantI;
    logic        grantD;
    logic [31:0] wMod;
    logic [31:0] rMod;
    logic [31:0] diffWR;
    logic [31:0] diffRW;
    logic [31:0] storeBytes;

    logic        iPend_q, iPend_d;
    logic        dPend_q, dPend_d;
    logic        lastRdData_q, lastRdData_d;
    logic        dKindWe_q, dKindWe_d;
    logic [1:0]  dKindSize_q, dKindSize_d;
    logic        dKindUns_q, dKindUns_d;

    // Distances are taken on addresses already reduced modulo SIZE so the wrap is exact for any SIZE.
    always_comb begin
        storeAcc  = d_req_valid & d_req_we;
        wMod      = d_req_addr % SIZE;
        rMod      = i_req_addr % SIZE;
        diffWR    = (wMod >= rMod) ? (wMod - rMod) : (wMod + SIZE - rMod);
        diffRW    = (rMod >= wMod) ? (rMod - wMod) : (rMod + SIZE - wMod);
        case (d_req_size)
            2'd1:    storeBytes = 32'd1;
            2'd2:    storeBytes = 32'd2;
            2'd3:    storeBytes = 32'd4;
            default: storeBytes = 32'd0;
        endcase
        overlap   = storeAcc & ((diffWR < 32'd4) | (diffRW < storeBytes));
        fetchCand = i_req_valid & ~overlap;
        loadCand  = d_req_valid & ~d_req_we;
        grantI    = fetchCand & (~loadCand | lastRdData_q);
        grantD    = loadCand & (~fetchCand | ~lastRdData_q);

        i_req_ready = grantI;
        d_req_ready = storeAcc | grantD;
        if (grantI)
            mem_rd_addr = i_req_addr;
        else if (grantD)
            mem_rd_addr = d_req_addr;
        else
            mem_rd_addr = 32'd0;
        mem_wr      = storeAcc ? d_req_size : 2'd0;
        mem_wr_addr = storeAcc ? d_req_addr : 32'd0;
        mem_wr_data = storeAcc ? d_req_wdata : 32'd0;

        iPend_d      = grantI;
        dPend_d      = storeAcc | grantD;
        lastRdData_d = grantD ? 1'b1 : (grantI ? 1'b0 : lastRdData_q);
        dKindWe_d    = dPend_d ? d_req_we : dKindWe_q;
        dKindSize_d  = dPend_d ? d_req_size : dKindSize_q;
        dKindUns_d   = dPend_d ? d_req_unsigned : dKindUns_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iPend_q      <= 1'b0;
            dPend_q      <= 1'b0;
            lastRdData_q <= 1'b1;
            dKindWe_q    <= 1'b0;
            dKindSize_q  <= 2'd0;
            dKindUns_q   <= 1'b0;
        end else begin
            iPend_q      <= iPend_d;
            dPend_q      <= dPend_d;
            lastRdData_q <= lastRdData_d;
            dKindWe_q    <= dKindWe_d;
            dKindSize_q  <= dKindSize_d;
            dKindUns_q   <= dKindUns_d;
        end
    end

    always_comb begin
        i_rsp_valid = iPend_q;
        i_rsp_data  = mem_rd_data;
        d_rsp_valid = dPend_q;
        d_rsp_data  = 32'd0;
        if (!dKindWe_q) begin
            case (dKindSize_q)
                2'd1:    d_rsp_data = {{24{~dKindUns_q & mem_rd_data[7]}}, mem_rd_data[7:0]};
                2'd2:    d_rsp_data = {{16{~dKindUns_q & mem_rd_data[15]}}, mem_rd_data[15:0]};
                2'd3:    d_rsp_data = mem_rd_data;
                default: d_rsp_data = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a byte memory model behind the ports and a
// separate reference byte array that predicts every response from the driven requests.
module tb_mem_port_arbiter;

    localparam int unsigned SIZE = 1024;

    logic        clk;
    logic        rst_n;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_req_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_we;
    logic [1:0]  d_req_size;
    logic        d_req_unsigned;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [1:0]  mem_wr;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_t;

    rsp_t        iQ[$];
    rsp_t        dQ[$];
    logic [7:0]  tbMem[SIZE];
    logic [7:0]  refMem[SIZE];
    int          checks = 0;
    int          failures = 0;
    int          cycleCnt = 0;

    mem_port_arbiter #(.SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_size(d_req_size), .d_req_unsigned(d_req_unsigned), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_wr(mem_wr),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Memory model: registered read of the old contents, then the sized write, wrapping modulo SIZE.
    always @(posedge clk) begin
        logic [31:0] a;
        logic [31:0] w;
        int          n;
        for (int i = 0; i < 4; i++) begin
            a = (mem_rd_addr + i) % SIZE;
            w[8*i +: 8] = tbMem[a];
        end
        mem_rd_data <= w;
        n = (mem_wr == 2'd3) ? 4 : int'(mem_wr);
        for (int i = 0; i < n; i++) begin
            a = (mem_wr_addr + i) % SIZE;
            tbMem[a] = mem_wr_data[8*i +: 8];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refWord(input logic [31:0] addr);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = refMem[(addr + i) % SIZE];
        return w;
    endfunction

    function automatic logic [31:0] extendLoad(input logic [31:0] w, input logic [1:0] size, input logic uns);
        case (size)
            2'd1:    return uns ? {24'd0, w[7:0]} : {{24{w[7]}}, w[7:0]};
            2'd2:    return uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            2'd3:    return w;
            default: return 32'd0;
        endcase
    endfunction

    // One cycle of requests: check readies and the write port, queue expected responses, update the reference.
    task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                                 input logic dv, input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] da, input logic [31:0] wd,
                                 input logic expIRdy, input logic expDRdy, input string tag);
        rsp_t e;
        int   n;
        i_req_valid = iv;  i_req_addr = ia;
        d_req_valid = dv;  d_req_we = we;  d_req_size = sz;
        d_req_unsigned = uns;  d_req_addr = da;  d_req_wdata = wd;
        @(negedge clk);
        checkOutput({tag, "_i_req_ready"}, {31'd0, i_req_ready}, {31'd0, expIRdy});
        checkOutput({tag, "_d_req_ready"}, {31'd0, d_req_ready}, {31'd0, expDRdy});
        checkOutput({tag, "_mem_wr"}, {30'd0, mem_wr}, (dv && we) ? {30'd0, sz} : 32'd0);
        if (dv && we && sz != 2'd0) begin
            checkOutput({tag, "_mem_wr_addr"}, mem_wr_addr, da);
            checkOutput({tag, "_mem_wr_data"}, mem_wr_data, wd);
        end
        if (iv && expIRdy) begin
            e.cyc = cycleCnt + 1;  e.data = refWord(ia);
            iQ.push_back(e);
        end
        if (dv && expDRdy) begin
            e.cyc = cycleCnt + 1;
            e.data = we ? 32'd0 : extendLoad(refWord(da), sz, uns);
            dQ.push_back(e);
        end
        if (dv && we) begin
            n = (sz == 2'd3) ? 4 : int'(sz);
            for (int i = 0; i < n; i++) refMem[(da + i) % SIZE] = wd[8*i +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++)
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "idle");
    endtask

    // Response side: every response must match the queue head and arrive exactly one cycle after acceptance.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n) begin
            if (i_rsp_valid) begin
                if (iQ.size() == 0) checkOutput("i_rsp_spurious", 32'd1, 32'd0);
                else begin
                    e = iQ.pop_front();
                    checkOutput("i_rsp_cycle", cycleCnt, e.cyc);
                    checkOutput("i_rsp_data", i_rsp_data, e.data);
                end
            end else if (iQ.size() > 0 && iQ[0].cyc <= cycleCnt) begin
                checkOutput("i_rsp_missing", 32'd0, 32'd1);
                void'(iQ.pop_front());
            end
            if (d_rsp_valid) begin
                if (dQ.size() == 0) checkOutput("d_rsp_spurious", 32'd1, 32'd0);
                else begin
                    e = dQ.pop_front();
                    checkOutput("d_rsp_cycle", cycleCnt, e.cyc);
                    checkOutput("d_rsp_data", d_rsp_data, e.data);
                end
            end else if (dQ.size() > 0 && dQ[0].cyc <= cycleCnt) begin
                checkOutput("d_rsp_missing", 32'd0, 32'd1);
                void'(dQ.pop_front());
            end
        end
    end

    initial begin
        #500000;
        checkOutput("watchdog", 32'd0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        for (int a = 0; a < SIZE; a++) begin
            tbMem[a]  = 8'(a) ^ 8'hA5;
            refMem[a] = 8'(a) ^ 8'hA5;
        end
        tbMem[0] = 8'h13;  tbMem[1] = 8'h05;  tbMem[2] = 8'h10;  tbMem[3] = 8'h00;
        refMem[0] = 8'h13; refMem[1] = 8'h05; refMem[2] = 8'h10; refMem[3] = 8'h00;
        rst_n = 1'b0;
        i_req_valid = 1'b0;  i_req_addr = 32'd0;
        d_req_valid = 1'b0;  d_req_we = 1'b0;  d_req_size = 2'd0;
        d_req_unsigned = 1'b0;  d_req_addr = 32'd0;  d_req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
        checkOutput("reset_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1, 32'h0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 0, "fetch0");
        applyStimulus(0, 32'h0, 1, 1, 2'd3, 0, 32'h10, 32'hDEADBEEF, 0, 1, "storeW");
        applyStimulus(0, 32'h0, 1, 0, 2'd1, 0, 32'h11, 32'h0, 0, 1, "lbS");
        applyStimulus(0, 32'h0, 1, 0, 2'd1, 1, 32'h11, 32'h0, 0, 1, "lbU");
        applyStimulus(0, 32'h0, 1, 0, 2'd2, 0, 32'h10, 32'h0, 0, 1, "lhS");

        // Last read grant was the load, so the tie starts with fetch and then alternates.
        for (int k = 0; k < 4; k++)
            applyStimulus(1, 32'h20, 1, 0, 2'd3, 0, 32'h40, 32'h0, (k % 2) == 0, (k % 2) == 1, "tie");

        applyStimulus(1, 32'h20, 1, 1, 2'd1, 0, 32'h23, 32'h00000077, 0, 1, "ovlByte");
        applyStimulus(1, 32'h20, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 0, "deferred");
        applyStimulus(1, 32'h20, 1, 1, 2'd3, 0, 32'h24, 32'h12345678, 1, 1, "adjacent");
        applyStimulus(1, 32'h0, 1, 1, 2'd2, 0, 32'h3FF, 32'h0000CAFE, 0, 1, "wrapOvl");
        applyStimulus(1, 32'h0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 0, "wrapFetch");
        applyStimulus(0, 32'h0, 1, 0, 2'd3, 0, 32'h3FE, 32'h0, 0, 1, "lwWrap");
        applyStimulus(0, 32'h0, 1, 1, 2'd0, 0, 32'h80, 32'hFFFFFFFF, 0, 1, "store0");
        applyStimulus(0, 32'h0, 1, 0, 2'd3, 0, 32'h80, 32'h0, 0, 1, "lwAfter0");
        applyStimulus(1, 32'h100, 1, 0, 2'd2, 1, 32'h41, 32'h0, 1, 0, "tieB0");
        applyStimulus(1, 32'h100, 1, 0, 2'd2, 1, 32'h41, 32'h0, 0, 1, "tieB1");

        // Reset in the cycle where the load's response is showing: it must vanish and never reappear.
        applyStimulus(0, 32'h0, 1, 0, 2'd3, 0, 32'h40, 32'h0, 0, 1, "preRst");
        d_req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midRst_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
        checkOutput("midRst_i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
        iQ.delete();
        dQ.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
        applyStimulus(1, 32'h20, 1, 0, 2'd3, 0, 32'h40, 32'h0, 1, 0, "postRstTie");
        applyStimulus(1, 32'h20, 1, 0, 2'd3, 0, 32'h40, 32'h0, 0, 1, "postRstTie2");
        idle(3);
        checkOutput("drain_iQ", iQ.size(), 32'd0);
        checkOutput("drain_dQ", dQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
